// File: rtl/tanh_2d_sequencer.sv
// Frame sequencer for the paired 2D tanh stage: scans the feature map two pixels
// per cycle, tracks each pair through the fixed-latency units and strobes write-back.
module tanh_2d_sequencer #(
    parameter int DATAWIDTH  = 32,
    parameter int IMAGE_SIZE = 28,
    parameter int TANH_LAT   = 1,
    parameter int IDXW       = $clog2(IMAGE_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 hold,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [IDXW-1:0]      rd_row,
    output logic [IDXW-1:0]      rd_col,
    input  logic [DATAWIDTH-1:0] rd_data0,
    input  logic [DATAWIDTH-1:0] rd_data1,
    output logic [DATAWIDTH-1:0] tanh_in0,
    output logic [DATAWIDTH-1:0] tanh_in1,
    output logic                 tanh_in_valid,
    input  logic [DATAWIDTH-1:0] tanh_out0,
    input  logic [DATAWIDTH-1:0] tanh_out1,
    output logic                 wr_en,
    output logic [IDXW-1:0]      wr_row,
    output logic [IDXW-1:0]      wr_col,
    output logic [DATAWIDTH-1:0] wr_data0,
    output logic [DATAWIDTH-1:0] wr_data1
);

    if (IMAGE_SIZE % 2 != 0) begin : g_bad_size
        $error("tanh_2d_sequencer: IMAGE_SIZE must be even");
    end
    if (TANH_LAT < 1 || TANH_LAT > 8) begin : g_bad_lat
        $error("tanh_2d_sequencer: TANH_LAT must be in 1..8");
    end

    localparam logic [IDXW-1:0] LAST_ROW = IDXW'(IMAGE_SIZE - 1);
    localparam logic [IDXW-1:0] LAST_COL = IDXW'(IMAGE_SIZE - 2);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [IDXW-1:0] row_cnt, col_cnt;
    logic            last_pair;
    logic            pipe_busy;

    logic [TANH_LAT:0] vld_p;
    logic [IDXW-1:0]   row_p [0:TANH_LAT];
    logic [IDXW-1:0]   col_p [0:TANH_LAT];

    assign last_pair = (row_cnt == LAST_ROW) && (col_cnt == LAST_COL);
    // The entry in the last stage is being written this cycle, so it does not keep DRAIN alive.
    assign pipe_busy = |vld_p[TANH_LAT-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ISSUE;
            end
            ISSUE: begin
                busy  = 1'b1;
                rd_en = !hold;
                if (!hold && last_pair) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!pipe_busy) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && start)) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (rd_en) begin
            if (col_cnt == LAST_COL) begin
                col_cnt <= '0;
                row_cnt <= last_pair ? '0 : row_cnt + IDXW'(1);
            end else begin
                col_cnt <= col_cnt + IDXW'(2);
            end
        end
    end

    assign rd_row = row_cnt;
    assign rd_col = col_cnt;

    // Stage 0: read data arrives; stages 1..TANH_LAT follow the tanh unit latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p <= '0;
            for (int i = 0; i <= TANH_LAT; i++) begin
                row_p[i] <= '0;
                col_p[i] <= '0;
            end
        end else begin
            vld_p    <= {vld_p[TANH_LAT-1:0], rd_en};
            row_p[0] <= row_cnt;
            col_p[0] <= col_cnt;
            for (int i = 1; i <= TANH_LAT; i++) begin
                row_p[i] <= row_p[i-1];
                col_p[i] <= col_p[i-1];
            end
        end
    end

    assign tanh_in0      = rd_data0;
    assign tanh_in1      = rd_data1;
    assign tanh_in_valid = vld_p[0];

    assign wr_en    = vld_p[TANH_LAT];
    assign wr_row   = row_p[TANH_LAT];
    assign wr_col   = col_p[TANH_LAT];
    assign wr_data0 = tanh_out0;
    assign wr_data1 = tanh_out1;

endmodule

// File: tb/tb_tanh_2d_sequencer.sv
// Bench for tanh_2d_sequencer: three instances (4/1, 28/1, 4/4) with emulated
// feature-map memory and tanh units (+1), checked against a pair-count model.
module tb_tanh_2d_sequencer;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset_i [NI];
    logic        start_i [NI];
    logic        hold_i  [NI];
    logic        busy_o  [NI];
    logic        done_o  [NI];
    logic        rd_en_o [NI];
    logic        tiv_o   [NI];
    logic        wr_en_o [NI];
    logic [31:0] rd_data0 [NI];
    logic [31:0] rd_data1 [NI];
    logic [31:0] tin0 [NI];
    logic [31:0] tin1 [NI];
    logic [31:0] tout0 [NI];
    logic [31:0] tout1 [NI];
    logic [31:0] wd0 [NI];
    logic [31:0] wd1 [NI];

    logic [1:0] rdr_a, rdc_a, wrr_a, wrc_a;
    logic [4:0] rdr_b, rdc_b, wrr_b, wrc_b;
    logic [1:0] rdr_c, rdc_c, wrr_c, wrc_c;
    int rd_row_i [NI];
    int rd_col_i [NI];
    int wr_row_i [NI];
    int wr_col_i [NI];

    assign rd_row_i[0] = 32'(rdr_a);
    assign rd_col_i[0] = 32'(rdc_a);
    assign wr_row_i[0] = 32'(wrr_a);
    assign wr_col_i[0] = 32'(wrc_a);
    assign rd_row_i[1] = 32'(rdr_b);
    assign rd_col_i[1] = 32'(rdc_b);
    assign wr_row_i[1] = 32'(wrr_b);
    assign wr_col_i[1] = 32'(wrc_b);
    assign rd_row_i[2] = 32'(rdr_c);
    assign rd_col_i[2] = 32'(rdc_c);
    assign wr_row_i[2] = 32'(wrr_c);
    assign wr_col_i[2] = 32'(wrc_c);

    tanh_2d_sequencer #(.DATAWIDTH(32), .IMAGE_SIZE(4), .TANH_LAT(1)) dut_a (
        .clk(clk), .reset(reset_i[0]), .start(start_i[0]), .hold(hold_i[0]),
        .busy(busy_o[0]), .done(done_o[0]), .rd_en(rd_en_o[0]),
        .rd_row(rdr_a), .rd_col(rdc_a), .rd_data0(rd_data0[0]), .rd_data1(rd_data1[0]),
        .tanh_in0(tin0[0]), .tanh_in1(tin1[0]), .tanh_in_valid(tiv_o[0]),
        .tanh_out0(tout0[0]), .tanh_out1(tout1[0]), .wr_en(wr_en_o[0]),
        .wr_row(wrr_a), .wr_col(wrc_a), .wr_data0(wd0[0]), .wr_data1(wd1[0])
    );

    tanh_2d_sequencer dut_b (
        .clk(clk), .reset(reset_i[1]), .start(start_i[1]), .hold(hold_i[1]),
        .busy(busy_o[1]), .done(done_o[1]), .rd_en(rd_en_o[1]),
        .rd_row(rdr_b), .rd_col(rdc_b), .rd_data0(rd_data0[1]), .rd_data1(rd_data1[1]),
        .tanh_in0(tin0[1]), .tanh_in1(tin1[1]), .tanh_in_valid(tiv_o[1]),
        .tanh_out0(tout0[1]), .tanh_out1(tout1[1]), .wr_en(wr_en_o[1]),
        .wr_row(wrr_b), .wr_col(wrc_b), .wr_data0(wd0[1]), .wr_data1(wd1[1])
    );

    tanh_2d_sequencer #(.DATAWIDTH(32), .IMAGE_SIZE(4), .TANH_LAT(4)) dut_c (
        .clk(clk), .reset(reset_i[2]), .start(start_i[2]), .hold(hold_i[2]),
        .busy(busy_o[2]), .done(done_o[2]), .rd_en(rd_en_o[2]),
        .rd_row(rdr_c), .rd_col(rdc_c), .rd_data0(rd_data0[2]), .rd_data1(rd_data1[2]),
        .tanh_in0(tin0[2]), .tanh_in1(tin1[2]), .tanh_in_valid(tiv_o[2]),
        .tanh_out0(tout0[2]), .tanh_out1(tout1[2]), .wr_en(wr_en_o[2]),
        .wr_row(wrr_c), .wr_col(wrc_c), .wr_data0(wd0[2]), .wr_data1(wd1[2])
    );

    function automatic logic [31:0] pix(int inst, int r, int c);
        return 32'(inst * 100000 + r * 256 + c * 3 + 5);
    endfunction

    // Feature-map memory (one-cycle read) and tanh units modelled as +1 with fixed latency.
    logic [31:0] tp0 [NI][4];
    logic [31:0] tp1 [NI][4];
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            rd_data0[i] <= pix(i, rd_row_i[i], rd_col_i[i]);
            rd_data1[i] <= pix(i, rd_row_i[i], rd_col_i[i] + 1);
            tp0[i][0]   <= tin0[i] + 32'd1;
            tp1[i][0]   <= tin1[i] + 32'd1;
            for (int k = 1; k < 4; k++) begin
                tp0[i][k] <= tp0[i][k-1];
                tp1[i][k] <= tp1[i][k-1];
            end
        end
    end
    assign tout0[0] = tp0[0][0];
    assign tout1[0] = tp1[0][0];
    assign tout0[1] = tp0[1][0];
    assign tout1[1] = tp1[1][0];
    assign tout0[2] = tp0[2][3];
    assign tout1[2] = tp1[2][3];

    int SZ [NI] = '{4, 28, 4};
    int LT [NI] = '{1, 1, 4};

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    int t0 [NI];
    int n_rd [NI];
    int n_wr [NI];
    int n_done [NI];
    int n_busy [NI];
    int first_rd [NI];
    int first_wr [NI];
    int last_wr [NI];
    int done_at [NI];

    task automatic chk(int inst, string what, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL dut%0d %s @rel cycle %0d: got %0d, expected %0d",
                      inst, what, cyc - t0[inst], act, exp);
    endtask

    task automatic clear_stats(int i);
        t0[i] = cyc;
        n_rd[i] = 0;
        n_wr[i] = 0;
        n_done[i] = 0;
        n_busy[i] = 0;
        first_rd[i] = -1;
        first_wr[i] = -1;
        last_wr[i] = -1;
        done_at[i] = -1;
    endtask

    // Model: a frame issues pairs 0..P-1 in row-major order on every un-held cycle;
    // each issue shows up as tanh_in_valid one cycle later and as a write 1+LAT later.
    bit m_act [NI];
    int m_iss [NI];
    int m_due [NI] = '{-1, -1, -1};
    bit h_en  [NI][16];
    int h_row [NI][16];
    int h_col [NI][16];

    int mc, mpc, mwc, e_row, e_col, rel, np;
    bit e_rd, e_wr, e_done, e_busy, e_tv;

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NI; i++) begin
                mc  = cyc;
                np  = SZ[i] * SZ[i] / 2;
                mpc = ((mc - 1) % 16 + 16) % 16;
                mwc = ((mc - 1 - LT[i]) % 16 + 16) % 16;
                e_rd   = m_act[i] && (m_iss[i] < np) && !hold_i[i];
                e_row  = m_iss[i] / (SZ[i] / 2);
                e_col  = 2 * (m_iss[i] % (SZ[i] / 2));
                e_wr   = h_en[i][mwc];
                e_tv   = h_en[i][mpc];
                e_done = (mc == m_due[i]);
                e_busy = m_act[i] && !e_done;

                chk(i, "busy", int'(busy_o[i]), int'(e_busy));
                chk(i, "done", int'(done_o[i]), int'(e_done));
                chk(i, "rd_en", int'(rd_en_o[i]), int'(e_rd));
                chk(i, "tanh_in_valid", int'(tiv_o[i]), int'(e_tv));
                chk(i, "wr_en", int'(wr_en_o[i]), int'(e_wr));
                if (e_rd) begin
                    chk(i, "rd_row", rd_row_i[i], e_row);
                    chk(i, "rd_col", rd_col_i[i], e_col);
                end
                if (e_tv) begin
                    chk(i, "tanh_in0", int'(tin0[i]), int'(pix(i, h_row[i][mpc], h_col[i][mpc])));
                    chk(i, "tanh_in1", int'(tin1[i]), int'(pix(i, h_row[i][mpc], h_col[i][mpc] + 1)));
                end
                if (e_wr) begin
                    chk(i, "wr_row", wr_row_i[i], h_row[i][mwc]);
                    chk(i, "wr_col", wr_col_i[i], h_col[i][mwc]);
                    chk(i, "wr_data0", int'(wd0[i]), int'(pix(i, h_row[i][mwc], h_col[i][mwc]) + 32'd1));
                    chk(i, "wr_data1", int'(wd1[i]), int'(pix(i, h_row[i][mwc], h_col[i][mwc] + 1) + 32'd1));
                end

                rel = mc - t0[i];
                if (rd_en_o[i]) begin
                    n_rd[i]++;
                    if (first_rd[i] < 0) first_rd[i] = rel;
                end
                if (wr_en_o[i]) begin
                    n_wr[i]++;
                    if (first_wr[i] < 0) first_wr[i] = rel;
                    last_wr[i] = rel;
                end
                if (done_o[i]) begin
                    n_done[i]++;
                    done_at[i] = rel;
                end
                if (busy_o[i]) n_busy[i]++;

                h_en[i][mc % 16]  = e_rd;
                h_row[i][mc % 16] = e_row;
                h_col[i][mc % 16] = e_col;
                if (e_rd) begin
                    m_iss[i]++;
                    if (m_iss[i] == np) m_due[i] = mc + 2 + LT[i];
                end
                if (e_done) begin
                    m_act[i] = 1'b0;
                    m_due[i] = -1;
                end else if (!m_act[i] && start_i[i]) begin
                    m_act[i] = 1'b1;
                    m_iss[i] = 0;
                end
                if (reset_i[i]) begin
                    m_act[i] = 1'b0;
                    m_iss[i] = 0;
                    m_due[i] = -1;
                    for (int k = 0; k < 16; k++) h_en[i][k] = 1'b0;
                end
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            reset_i[i] = 1'b1;
            start_i[i] = 1'b0;
            hold_i[i]  = 1'b0;
            clear_stats(i);
        end
        step(3);
        for (int i = 0; i < NI; i++) reset_i[i] = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        chk(0, "reset busy", int'(busy_o[0]), 0);
        chk(0, "reset rd_row", rd_row_i[0], 0);
        chk(0, "reset wr_row", wr_row_i[0], 0);
        chk(0, "reset wr_col", wr_col_i[0], 0);
        step(1);

        // Plain frame on all three instances.
        for (int i = 0; i < NI; i++) begin
            start_i[i] = 1'b1;
            clear_stats(i);
        end
        step(1);
        for (int i = 0; i < NI; i++) start_i[i] = 1'b0;
        step(14);
        chk(0, "t1 rd count", n_rd[0], 8);
        chk(0, "t1 first rd", first_rd[0], 1);
        chk(0, "t1 wr count", n_wr[0], 8);
        chk(0, "t1 first wr", first_wr[0], 3);
        chk(0, "t1 last wr", last_wr[0], 10);
        chk(0, "t1 done cycle", done_at[0], 11);
        chk(0, "t1 done count", n_done[0], 1);
        chk(0, "t1 busy cycles", n_busy[0], 10);

        // Hold during cycles 3..5.
        clear_stats(0);
        start_i[0] = 1'b1;
        step(1);
        start_i[0] = 1'b0;
        step(2);
        hold_i[0] = 1'b1;
        step(3);
        hold_i[0] = 1'b0;
        @(negedge clk);
        chk(0, "t2 rd_en c6", int'(rd_en_o[0]), 1);
        chk(0, "t2 rd_row c6", rd_row_i[0], 1);
        chk(0, "t2 rd_col c6", rd_col_i[0], 0);
        step(12);
        chk(0, "t2 rd count", n_rd[0], 8);
        chk(0, "t2 wr count", n_wr[0], 8);
        chk(0, "t2 done cycle", done_at[0], 14);
        chk(0, "t2 done count", n_done[0], 1);

        // Start pulses mid-frame and in the DONE cycle are ignored.
        clear_stats(0);
        start_i[0] = 1'b1;
        step(1);
        start_i[0] = 1'b0;
        step(3);
        start_i[0] = 1'b1;
        step(1);
        start_i[0] = 1'b0;
        step(6);
        start_i[0] = 1'b1;
        step(1);
        start_i[0] = 1'b0;
        step(4);
        chk(0, "t3 wr count", n_wr[0], 8);
        chk(0, "t3 done count", n_done[0], 1);
        chk(0, "t3 done cycle", done_at[0], 11);
        chk(0, "t3 idle busy", int'(busy_o[0]), 0);

        // Reset mid-frame with pairs in flight, then restart.
        clear_stats(0);
        start_i[0] = 1'b1;
        step(1);
        start_i[0] = 1'b0;
        step(4);
        reset_i[0] = 1'b1;
        step(1);
        reset_i[0] = 1'b0;
        @(negedge clk);
        chk(0, "t4 wr_en", int'(wr_en_o[0]), 0);
        chk(0, "t4 busy", int'(busy_o[0]), 0);
        chk(0, "t4 tanh_in_valid", int'(tiv_o[0]), 0);
        chk(0, "t4 rd_row", rd_row_i[0], 0);
        chk(0, "t4 rd_col", rd_col_i[0], 0);
        chk(0, "t4 wr_row", wr_row_i[0], 0);
        chk(0, "t4 wr_col", wr_col_i[0], 0);
        step(2);
        chk(0, "t4 no done", n_done[0], 0);
        clear_stats(0);
        start_i[0] = 1'b1;
        step(1);
        start_i[0] = 1'b0;
        @(negedge clk);
        chk(0, "t4 restart rd_en", int'(rd_en_o[0]), 1);
        chk(0, "t4 restart row", rd_row_i[0], 0);
        chk(0, "t4 restart col", rd_col_i[0], 0);
        step(13);
        chk(0, "t4 wr count", n_wr[0], 8);
        chk(0, "t4 done cycle", done_at[0], 11);
        chk(0, "t4 done count", n_done[0], 1);

        // Full-size frame and long-latency frame, started together with test 1.
        while (cyc < t0[1] + 400) step(1);
        chk(1, "full wr count", n_wr[1], 392);
        chk(1, "full rd count", n_rd[1], 392);
        chk(1, "full first wr", first_wr[1], 3);
        chk(1, "full last wr", last_wr[1], 394);
        chk(1, "full done cycle", done_at[1], 395);
        chk(1, "full done count", n_done[1], 1);
        chk(2, "lat4 first wr", first_wr[2], 6);
        chk(2, "lat4 last wr", last_wr[2], 13);
        chk(2, "lat4 done cycle", done_at[2], 14);
        chk(2, "lat4 wr count", n_wr[2], 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tanh_2d_sequencer.md
Name: tanh_2d_sequencer

Overview:
- Frame-level controller for the 2D tanh activation stage.
- On `start`, it scans an IMAGE_SIZE x IMAGE_SIZE feature map in row-major order and issues two adjacent pixels per cycle to a pair of fixed-latency tanh units.
- It tracks each pair through the unit pipeline, emits write-back strobes with the matching row/column, and signals frame completion.
- It sits between the feature-map buffer (synchronous read port) and the activation output buffer.

Parameters:
- DATAWIDTH, 32, pixel word width.
- IMAGE_SIZE, 28, feature-map side length; must be even (elaboration error otherwise).
- TANH_LAT, 1, fixed latency in clocks of each tanh unit, from input to output; range 1..8.
- IDXW, $clog2(IMAGE_SIZE), row/column index width (derived).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- start  input  1  begin a frame; sampled only in IDLE
- hold  input  1  suspend issuing new pairs; in-flight pairs continue
- busy  output  1  high in ISSUE and DRAIN
- done  output  1  one-cycle pulse at frame completion
- rd_en  output  1  feature-map read strobe for a pixel pair
- rd_row  output  IDXW  read row
- rd_col  output  IDXW  read column of first pixel (always even)
- rd_data0  input  DATAWIDTH  pixel [row][col]; valid one cycle after rd_en
- rd_data1  input  DATAWIDTH  pixel [row][col+1]; valid one cycle after rd_en
- tanh_in0  output  DATAWIDTH  to tanh unit 0; wire of rd_data0
- tanh_in1  output  DATAWIDTH  to tanh unit 1; wire of rd_data1
- tanh_in_valid  output  1  rd_en delayed one cycle
- tanh_out0  input  DATAWIDTH  unit 0 result
- tanh_out1  input  DATAWIDTH  unit 1 result
- wr_en  output  1  output-buffer write strobe
- wr_row  output  IDXW  write row
- wr_col  output  IDXW  write column of first result (even)
- wr_data0  output  DATAWIDTH  wire of tanh_out0
- wr_data1  output  DATAWIDTH  wire of tanh_out1

Behaviour:
- Reset (synchronous, highest priority, legal mid-frame):
  - state returns to IDLE; row/col counters go to 0; the pipeline valid/address shift register is cleared.
  - busy, done, rd_en, tanh_in_valid and wr_en are all 0 on the next cycle.
  - No write is issued for pairs that were in flight.
  - rd_row, rd_col, wr_row and wr_col read 0 after reset.
- FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
  - IDLE: start=1 moves to ISSUE next cycle and clears the counters. start is ignored in every other state.
  - ISSUE: rd_en = !hold (combinational gate, registered counters). rd_row/rd_col come from the counters.
  - Each cycle with rd_en=1: col += 2. When col = IMAGE_SIZE-2, col wraps to 0 and row += 1.
  - Issuing pair (IMAGE_SIZE-1, IMAGE_SIZE-2) moves the FSM to DRAIN next cycle.
  - hold=1 freezes the counters and deasserts rd_en; it has no effect outside ISSUE.
  - DRAIN: no issue. Moves to DONE in the cycle after the shift register holds no valid entry.
  - DONE: done=1 for exactly one cycle, then IDLE. start in DONE is ignored.
- Latency:
  - Pair issued (rd_en) in cycle t gives tanh_in_valid at t+1 and wr_en at t+1+TANH_LAT.
  - wr_row/wr_col carry the address issued at t, delayed 1+TANH_LAT cycles through the shift register.
- Count:
  - Exactly IMAGE_SIZE*IMAGE_SIZE/2 rd_en pulses and the same number of wr_en pulses per frame.
  - Each (row, even col) pair is issued exactly once, in row-major order.
  - Without hold: rd_en occupies cycles 1..P, wr_en occupies 2+TANH_LAT..P+1+TANH_LAT, and done is at P+2+TANH_LAT, where start is sampled at cycle 0 and P = pair count.
- Writes are never stalled; hold only throttles issue. An empty cycle in the pipeline produces wr_en=0.

Test Plan:
- IMAGE_SIZE=4, TANH_LAT=1, start at cycle 0, hold=0 -> rd_en cycles 1..8 with (row,col) sequence (0,0),(0,2),(1,0)…(3,2); wr_en cycles 3..10 with the same sequence; done=1 only at cycle 11; busy cycles 1..10.
- IMAGE_SIZE=4, hold=1 during cycles 3..5 -> rd_en low in cycles 3..5; (1,0) issued at cycle 6; still 8 writes; done at cycle 14; no duplicated or skipped address.
- Pulse start at cycle 4 mid-frame, and again in the DONE cycle -> both ignored; exactly 8 writes; FSM returns to IDLE.
- Reset asserted at cycle 5 with pairs in flight -> from cycle 6 wr_en=0, busy=0, done never pulses; a new start at cycle 8 restarts at (0,0).
- Default parameters (28, TANH_LAT=1), scoreboard with tanh_out = tanh_in + 1 model -> 392 writes; each wr_data0/1 equals the model of pixel [r][c]/[r][c+1]; done at cycle 395.
- TANH_LAT=4, IMAGE_SIZE=4 -> first wr_en at cycle 6, last at cycle 13, done at cycle 14.
